// File: rtl/aes_ctr_sequencer.sv
// CTR-mode sequencer between the register front end and an AES-128 core:
// loads counter blocks, waits for the keystream, XORs it with plaintext.
module aes_ctr_sequencer #(
  parameter int CTR_WIDTH = 32,
  parameter int TIMEOUT   = 64
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         start,
  input  logic [127:0] cfg_key,
  input  logic [127:0] cfg_iv,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic         error,
  output logic [15:0]  blk_count,
  output logic         core_rst_n,
  output logic         core_ld,
  output logic [127:0] core_key,
  output logic [127:0] core_text_in,
  input  logic         core_done,
  input  logic [127:0] core_text_out
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [127:0] CTR_MASK =
    (CTR_WIDTH >= 128) ? '1 : ((128'd1 << CTR_WIDTH) - 128'd1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_OUT} state_t;

  state_t          state;
  logic            armed;
  logic [127:0]    counter, key, pt;
  logic [WD_W-1:0] wd_cnt;
  logic [127:0]    ctr_next;

  // Only the low CTR_WIDTH bits advance; the nonce part above is preserved.
  assign ctr_next     = (counter & ~CTR_MASK) | ((counter + 128'd1) & CTR_MASK);
  assign in_ready     = (state == S_IDLE) & armed & ~error;
  assign busy         = (state != S_IDLE);
  assign core_key     = key;
  assign core_text_in = counter;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= S_IDLE;
      armed      <= 1'b0;
      error      <= 1'b0;
      blk_count  <= '0;
      counter    <= '0;
      key        <= '0;
      pt         <= '0;
      wd_cnt     <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      core_ld    <= 1'b0;
      core_rst_n <= 1'b0;
    end else begin
      core_rst_n <= 1'b1;
      core_ld    <= 1'b0;
      case (state)
        S_IDLE: begin
          // start has priority: in_ready is still low on the arming cycle
          if (start) begin
            counter    <= cfg_iv;
            key        <= cfg_key;
            blk_count  <= '0;
            error      <= 1'b0;
            armed      <= 1'b1;
            core_rst_n <= 1'b0;
          end else if (in_valid && in_ready) begin
            pt      <= in_data;
            core_ld <= 1'b1;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          wd_cnt <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (core_done) begin
            out_data  <= core_text_out ^ pt;
            out_valid <= 1'b1;
            counter   <= ctr_next;
            if (blk_count != 16'hFFFF) blk_count <= blk_count + 16'd1;
            state     <= S_OUT;
          end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
            error <= 1'b1;
            armed <= 1'b0;
            state <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/aes_ctr_sequencer.md
Name: aes_ctr_sequencer

Overview:
- Counter-mode (CTR) sequencer placed between the Wishbone register front end and the AES-128 cipher core.
- Accepts 128-bit plaintext blocks on a valid/ready stream and loads the current counter block into the cipher core.
- Waits for the core's done pulse, then XORs the keystream with the held plaintext and presents the ciphertext on an output valid/ready stream.
- Owns the counter increment, core reset sequencing and a done watchdog.

Parameters:
- CTR_WIDTH, 32: number of low counter bits that increment; wrap is modulo 2^CTR_WIDTH and the upper 128-CTR_WIDTH bits are untouched. Legal range 1..128.
- TIMEOUT, 64: maximum cycles in WAIT without core_done before error is raised.

Ports:
- wb_clk_i  input  1  sole clock.
- wb_rst_i  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; arms the sequencer with cfg_iv and cfg_key.
- cfg_key  input  128  AES key, sampled on an accepted start.
- cfg_iv  input  128  initial counter block, sampled on an accepted start.
- in_valid  input  1  plaintext block valid.
- in_ready  output  1  sequencer accepts a plaintext block.
- in_data  input  128  plaintext block.
- out_valid  output  1  ciphertext block valid.
- out_ready  input  1  downstream accepts the ciphertext block.
- out_data  output  128  ciphertext block.
- busy  output  1  high in LOAD, WAIT or OUT.
- error  output  1  sticky watchdog error.
- blk_count  output  16  blocks completed since the last start; saturates at 16'hFFFF.
- core_rst_n  output  1  active-low reset to the cipher core.
- core_ld  output  1  one-cycle load strobe to the core.
- core_key  output  128  latched key.
- core_text_in  output  128  counter block.
- core_done  input  1  core completion pulse.
- core_text_out  input  128  keystream block from the core.

Behaviour:
- Reset values (async, on wb_rst_i high):
  - state=IDLE, armed=0, error=0, blk_count=0.
  - counter, key and plaintext registers = 0.
  - out_valid=0, out_data=0, core_ld=0, core_rst_n=0, in_ready=0, busy=0.
- core_rst_n goes to 1 on the first clock after reset release.
- core_rst_n is driven 0 for exactly one cycle following an accepted start, to flush the core.
- All outputs are registered except in_ready and busy, which decode combinationally from state and armed.
- States:
  - IDLE: in_ready = armed & ~error.
    - start pulse: counter<=cfg_iv, key<=cfg_key, blk_count<=0, error<=0, armed<=1.
    - start is accepted only in IDLE; it is ignored in every other state.
    - If start and in_valid are both high in the same cycle, start wins and the block is not accepted (in_ready is evaluated before arming).
    - in_valid & in_ready: pt<=in_data, go to LOAD.
  - LOAD, 1 cycle: core_ld=1, core_text_in=counter; go to WAIT and clear the watchdog count.
  - WAIT: the watchdog count increments every cycle.
    - core_done=1: out_data<=core_text_out ^ pt, out_valid<=1.
    - Same cycle: counter[CTR_WIDTH-1:0]+=1 with wrap, blk_count+=1 saturating; go to OUT.
    - Watchdog count reaching TIMEOUT with no done: error<=1, armed<=0, go to IDLE; no output is produced and the counter is not advanced.
    - If core_done arrives in the same cycle the watchdog count reaches TIMEOUT, done wins.
  - OUT: out_valid held and out_data stable until out_ready.
    - On the handshake, out_valid<=0 and go to IDLE.
    - in_ready=0 throughout OUT; there is no bypass.
- core_done outside WAIT is ignored.
- core_key = key register at all times.
- core_text_in holds the counter register at all times (valid during LOAD).
- Latency:
  - Input handshake to core_ld: 1 cycle.
  - core_done to out_valid: 1 cycle.
  - Minimum block period: core latency + 3 cycles.
- Reset mid-operation: aborts immediately to reset values; any in-flight block is discarded.

Test Plan:
- FIPS-197 keystream: key 000102030405060708090a0b0c0d0e0f, IV 00112233445566778899aabbccddeeff, plaintext 0 -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, blk_count=1, core_text_in=IV during LOAD.
- Counter wrap: IV low word FFFFFFFF (upper 96 bits A5A5...), two blocks -> second core_text_in low word 00000000, upper 96 bits unchanged, blk_count=2.
- Backpressure: out_ready low for 10 cycles after out_valid -> out_data stable, in_ready=0 with in_valid=1, no core_ld; releasing out_ready -> one handshake, return to IDLE.
- Watchdog: stub core never asserts done -> error=1 exactly TIMEOUT (64) cycles after LOAD, in_ready=0, busy=0; a following start clears error, rearms, and the next block completes.
- Control corner cases: start pulsed during WAIT -> ignored, counter unchanged; start together with in_valid in an unarmed IDLE -> armed, block not taken; core_rst_n low exactly 1 cycle after the start.
- Async reset: assert wb_rst_i mid-WAIT -> out_valid, core_ld, busy, error, blk_count and core_rst_n all 0 immediately without a clock edge; core_done afterwards has no effect.
